// File: rtl/regdump_uart_tx_pkg.sv
// Shared constants, FSM encoding and byte-select helper for the register dump UART.
// Pure declarations; no timing or flow control.
package regdump_uart_tx_pkg;

    localparam logic [7:0] HDR_BYTE      = 8'hA5;
    localparam int         NUM_REGS      = 16;
    localparam int         BYTES_PER_REG = 4;
    localparam logic [3:0] LAST_REG      = 4'(NUM_REGS - 1);
    localparam logic [1:0] LAST_BYTE     = 2'(BYTES_PER_REG - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_SEL,
        ST_CAP,
        ST_DONE
    } state_e;

    // Big-endian byte pick: index 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: txd goes low the cycle after load; each bit lasts CLKS_PER_BIT cycles.
// ready flags the last stop-bit cycle so a load there gives back-to-back bytes; no other backpressure.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       txd_o,
    output logic       ready_o
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_STOP = 4'd9;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shr_q, shr_d;
    logic          active_q, active_d;
    logic          txd_q, txd_d;

    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shr_d    = shr_q;
        active_d = active_q;
        txd_d    = txd_q;
        if (load_i) begin
            cnt_d    = '0;
            bit_d    = '0;
            shr_d    = data_i;
            active_d = 1'b1;
            txd_d    = 1'b0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (bit_q == BIT_STOP) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    // bit_q is the bit just finished; after data bit 7 comes the stop bit
                    bit_d = bit_q + 4'd1;
                    txd_d = (bit_q == 4'd8) ? 1'b1 : shr_q[0];
                    shr_d = {1'b0, shr_q[7:1]};
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            shr_q    <= '0;
            active_q <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shr_q    <= shr_d;
            active_q <= active_d;
            txd_q    <= txd_d;
        end
    end

    assign txd_o   = txd_q;
    assign ready_o = active_q && (bit_q == BIT_STOP) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/regdump_uart_tx.sv
// Walks dbg_sel over R0..R15 and streams A5 + 16 big-endian words over UART 8N1.
// Busy for 650*CLKS_PER_BIT+32 cycles from the edge after start; start is dropped unless IDLE.
module regdump_uart_tx
    import regdump_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] dbg_val_i,
    output logic [3:0]  dbg_sel_o,
    output logic        txd_o,
    output logic        busy_o,
    output logic        done_o
);

    state_e      state_q, state_d;
    logic [3:0]  reg_q, reg_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] word_q, word_d;
    logic        hdr_q, hdr_d;
    logic [3:0]  sel_q, sel_d;
    logic        load;
    logic [7:0]  load_dat;
    logic        ser_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .data_i (load_dat),
        .txd_o  (txd_o),
        .ready_o(ser_ready)
    );

    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        byte_d   = byte_q;
        word_d   = word_q;
        hdr_d    = hdr_q;
        sel_d    = sel_q;
        load     = 1'b0;
        load_dat = HDR_BYTE;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    hdr_d   = 1'b1;
                    reg_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ser_ready) begin
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = ST_SEL;
                    end else if (byte_q < LAST_BYTE) begin
                        byte_d   = byte_q + 2'd1;
                        load     = 1'b1;
                        load_dat = word_byte(word_q, byte_d);
                    end else if (reg_q < LAST_REG) begin
                        reg_d   = reg_q + 4'd1;
                        state_d = ST_SEL;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SEL: begin
                sel_d   = reg_q;
                state_d = ST_CAP;
            end
            // dbg_sel has settled for a full cycle; the processor value is sampled here only
            ST_CAP: begin
                word_d   = dbg_val_i;
                byte_d   = '0;
                load     = 1'b1;
                load_dat = dbg_val_i[31:24];
                state_d  = ST_SEND;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            hdr_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            hdr_q   <= hdr_d;
            sel_q   <= sel_d;
        end
    end

    assign dbg_sel_o = sel_q;
    assign busy_o    = (state_q == ST_SEND) || (state_q == ST_SEL) || (state_q == ST_CAP);
    assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_regdump_uart_tx.sv
// Bench for regdump_uart_tx at CLKS_PER_BIT=4: records txd/busy/done per cycle and checks
// them against an ideal frame built from the byte list, plus an independent UART decode.
module tb_regdump_uart_tx;

    localparam int CPB      = 4;
    localparam int BIT_CYC  = 10 * CPB;
    localparam int BUSY_CYC = 650 * CPB + 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dbg_val;
    logic [3:0]  dbg_sel;
    logic        txd;
    logic        busy;
    logic        done;

    logic ovr_arm = 1'b0;
    logic r3_new  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int inj_a;
    int inj_b;

    logic       tx_q[$];
    logic       busy_q[$];
    logic       done_q[$];
    logic [7:0] exp_b[$];
    logic       exp_w[$];

    always #5 clk = ~clk;

    // R3 changes value right after the edge that ends its CAP cycle
    always @(posedge clk) begin
        if (!ovr_arm)
            r3_new <= 1'b0;
        else if (dbg_sel == 4'd3)
            r3_new <= 1'b1;
    end

    assign dbg_val = (r3_new && dbg_sel == 4'd3) ? 32'h12345678 : (32'hDEAD0000 | {28'd0, dbg_sel});

    regdump_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .dbg_val_i(dbg_val),
        .dbg_sel_o(dbg_sel),
        .txd_o    (txd),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic build_expected();
        logic [31:0] v;
        exp_b.delete();
        exp_w.delete();
        exp_b.push_back(8'hA5);
        for (int r = 0; r < 16; r++) begin
            v = 32'hDEAD0000 + r;
            exp_b.push_back(v[31:24]);
            exp_b.push_back(v[23:16]);
            exp_b.push_back(v[15:8]);
            exp_b.push_back(v[7:0]);
        end
        for (int k = 0; k < 65; k++) begin
            if (k > 0 && (k - 1) % 4 == 0) begin
                exp_w.push_back(1'b1);
                exp_w.push_back(1'b1);
            end
            for (int c = 0; c < CPB; c++) exp_w.push_back(1'b0);
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < CPB; c++) exp_w.push_back(exp_b[k][b]);
            for (int c = 0; c < CPB; c++) exp_w.push_back(1'b1);
        end
    endtask

    // Pulse start, then record from the first cycle after the accepting edge until done+tail.
    task automatic run_frame(input bit inj, input int tail);
        int idx      = 0;
        int done_idx = -1;
        bit to       = 1'b0;
        tx_q.delete();
        busy_q.delete();
        done_q.delete();
        @(negedge clk);
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            tx_q.push_back(txd);
            busy_q.push_back(busy);
            done_q.push_back(done);
            if (done === 1'b1 && done_idx < 0) done_idx = idx;
            start = inj && (idx == inj_a || idx == inj_b || idx == BUSY_CYC - 1 || done === 1'b1);
            if (done_idx >= 0 && idx >= done_idx + tail) break;
            idx++;
            if (idx >= 3200) begin
                to = 1'b1;
                break;
            end
        end
        n_checks++;
        if (to) begin
            n_errors++;
            $display("FAIL frame_timeout: done not seen within %0d cycles, required by cycle %0d", idx, BUSY_CYC);
        end
    endtask

    task automatic analyze_frame(input string tag);
        logic       e;
        logic [7:0] by;
        logic [7:0] dec_b[$];
        int         dec_p[$];
        int wmis, first_bad, bl, btail, dn, dpos, ferr, i, nbad, bad_at, gbad, g;
        build_expected();

        wmis = 0;
        first_bad = -1;
        for (int j = 0; j < tx_q.size(); j++) begin
            e = (j < exp_w.size()) ? exp_w[j] : 1'b1;
            if (tx_q[j] !== e) begin
                wmis++;
                if (first_bad < 0) first_bad = j;
            end
        end
        n_checks++;
        if (wmis != 0 || tx_q.size() < exp_w.size()) begin
            n_errors++;
            $display("FAIL %s txd_wave: %0d cycles differ (first at %0d), %0d cycles recorded, need 0 differing over %0d",
                     tag, wmis, first_bad, tx_q.size(), exp_w.size());
        end

        bl = 0;
        while (bl < busy_q.size() && busy_q[bl] === 1'b1) bl++;
        btail = 0;
        for (int j = bl; j < busy_q.size(); j++) if (busy_q[j] !== 1'b0) btail++;
        n_checks++;
        if (bl != BUSY_CYC || btail != 0) begin
            n_errors++;
            $display("FAIL %s busy_len: high %0d cycles then %0d stray, required %0d then 0", tag, bl, btail, BUSY_CYC);
        end

        dn = 0;
        dpos = -1;
        for (int j = 0; j < done_q.size(); j++) begin
            if (done_q[j] !== 1'b0) begin
                dn++;
                if (dpos < 0) dpos = j;
            end
        end
        n_checks++;
        if (dn != 1 || dpos != BUSY_CYC) begin
            n_errors++;
            $display("FAIL %s done_pulse: %0d cycles high, first at %0d, required 1 at %0d", tag, dn, dpos, BUSY_CYC);
        end

        // Independent UART receiver: mid-bit sampling after each falling edge
        i = 0;
        ferr = 0;
        while (i + BIT_CYC <= tx_q.size()) begin
            if (tx_q[i] === 1'b0) begin
                by = '0;
                for (int b = 0; b < 8; b++) by[b] = tx_q[i + CPB * (b + 1) + CPB / 2];
                if (tx_q[i + 9 * CPB + CPB / 2] !== 1'b1) ferr++;
                dec_b.push_back(by);
                dec_p.push_back(i);
                i += BIT_CYC - 1;
            end else begin
                i++;
            end
        end
        n_checks++;
        if (dec_b.size() != 65 || ferr != 0) begin
            n_errors++;
            $display("FAIL %s byte_count: %0d bytes, %0d framing errors, required 65 bytes, 0 errors", tag, dec_b.size(), ferr);
        end

        nbad = 0;
        bad_at = -1;
        for (int j = 0; j < dec_b.size() && j < exp_b.size(); j++) begin
            if (dec_b[j] !== exp_b[j]) begin
                nbad++;
                if (bad_at < 0) bad_at = j;
            end
        end
        n_checks++;
        if (nbad != 0 || dec_b.size() != exp_b.size()) begin
            n_errors++;
            if (bad_at >= 0)
                $display("FAIL %s byte_data: byte %0d is %h, required %h (%0d bad)", tag, bad_at, dec_b[bad_at], exp_b[bad_at], nbad);
            else
                $display("FAIL %s byte_data: %0d bytes decoded, required %0d", tag, dec_b.size(), exp_b.size());
        end

        n_checks++;
        if (dec_p.size() == 0 || dec_p[0] != 0) begin
            n_errors++;
            $display("FAIL %s first_start: header start bit at cycle %0d, required 0", tag,
                     (dec_p.size() == 0) ? -1 : dec_p[0]);
        end

        gbad = 0;
        for (int j = 1; j < dec_p.size(); j++) begin
            g = dec_p[j] - dec_p[j - 1] - BIT_CYC;
            if (g != (((j - 1) % 4 == 0) ? 2 : 0)) gbad++;
        end
        n_checks++;
        if (gbad != 0 || dec_p.size() < 2) begin
            n_errors++;
            $display("FAIL %s idle_gaps: %0d wrong inter-byte gaps over %0d bytes, required 0", tag, gbad, dec_p.size());
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (txd !== 1'b1) begin n_errors++; $display("FAIL reset_txd: got %b, required 1", txd); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++;
        if (dbg_sel !== 4'd0) begin n_errors++; $display("FAIL reset_dbg_sel: got %h, required 0", dbg_sel); end
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dbg_sel !== 4'd0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL quiet_idle: %0d active cycles without start, required 0", bad);
        end
    endtask

    task automatic test_full_dump();
        run_frame(1'b0, 4);
        analyze_frame("full_dump");
    endtask

    task automatic test_start_while_busy();
        inj_a = $urandom_range(1, 1300);
        inj_b = $urandom_range(1301, BUSY_CYC - 2);
        run_frame(1'b1, 0);
        analyze_frame("start_while_busy");
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 4);
        analyze_frame("back_to_back");
    endtask

    task automatic test_reset_mid_dump(input int k, input string tag);
        int target;
        target = BIT_CYC * k + 2 * ((k - 1) / 4 + 1) + 15;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (target) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || dbg_sel !== 4'((k - 1) / 4)) begin
            n_errors++;
            $display("FAIL %s pre_reset: busy=%b dbg_sel=%h, required busy=1 dbg_sel=%h", tag, busy, dbg_sel, 4'((k - 1) / 4));
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || dbg_sel !== 4'd0) begin
            n_errors++;
            $display("FAIL %s post_reset: txd=%b busy=%b done=%b dbg_sel=%h, required 1 0 0 0", tag, txd, busy, done, dbg_sel);
        end
        reset = 1'b0;
        run_frame(1'b0, 4);
        analyze_frame(tag);
    endtask

    task automatic test_capture_point();
        ovr_arm = 1'b1;
        run_frame(1'b0, 4);
        n_checks++;
        if (r3_new !== 1'b1) begin
            n_errors++;
            $display("FAIL capture_override: R3 change applied=%b, required 1", r3_new);
        end
        analyze_frame("capture_point");
        ovr_arm = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_dump(23, "reset_mid_r5b2");
        test_reset_mid_dump($urandom_range(1, 64), "reset_mid_random");
        test_capture_point();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regdump_uart_tx.md
# regdump_uart_tx

Debug-side reader for the processor's register debug port. On a start pulse it walks the debug register select through R0..R15 and captures each 32-bit value. It sends a framed binary dump over a UART 8N1 serial line. It sits at board top level beside the single-cycle processor, driving the processor's debug-register select input and consuming its debug-register value output.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- clk  input  1  system clock, shared with the processor.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a dump; sampled only in IDLE.
- dbg_val  input  32  value of the selected register, combinational from the processor's debug port.
- dbg_sel  output  4  registered register index driven to the processor's debug port.
- txd  output  1  UART serial out; idle high.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse when a dump completes.

## Operation
- Reset values: txd=1, busy=0, done=0, dbg_sel=0, all counters 0, state IDLE.
- Frame: header byte 8'hA5, then R0..R15, each as 4 bytes big-endian (bits [31:24] first). Total 65 bytes.
- Byte format: start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: on start, load 8'hA5 and go to SEND.
  - SEND: serialize one byte. After the last stop-bit cycle:
    - header just sent: go to SEL.
    - byte_idx<3: load the next byte of the captured word, byte_idx++, stay in SEND.
    - byte_idx==3 and reg_idx<15: reg_idx++, go to SEL.
    - byte_idx==3 and reg_idx==15: go to DONE.
  - SEL: dbg_sel=reg_idx.
  - CAP: latch dbg_val into the word register at the end of the cycle; byte_idx=0; load word[31:24] and go to SEND.
  - DONE: done=1 for one cycle, then go to IDLE.
- dbg_sel holds its last value (15) after a dump. It returns to 0 only on reset or at the next dump's first SEL.
- The capture is not atomic across registers. Each value is the register contents at its CAP cycle. An atomic snapshot requires the processor clock to be gated externally.
- start while busy=1 is ignored; it is not queued.
- Reset mid-dump: the next edge forces all outputs to reset values. The partial byte is truncated (the host sees a framing error). The next start begins a fresh frame with the header.

## Timing
- Start accepted at edge t: busy=1 and txd=0 (header start bit) from t+1.
- Bytes within a register are back-to-back: a stop bit is followed immediately by the next start bit.
- Between the header and R0, and between consecutive registers, there are exactly 2 idle-high cycles (SEL, CAP).
- busy duration is exactly 650·CLKS_PER_BIT + 32 cycles.
- done is high in the first cycle after busy falls. A start in that cycle is ignored, because the FSM is still in DONE.
- Bit counter: $clog2(CLKS_PER_BIT) bits. Bit index runs 0..9 (start, 8 data, stop).
- reg_idx is 4 bits and byte_idx is 2 bits. Termination uses explicit compares, not wrap.

## Structure
- Shared package holds:
  - HDR_BYTE = 8'hA5, NUM_REGS = 16, BYTES_PER_REG = 4.
  - FSM state encoding: IDLE, SEND, SEL, CAP, DONE.
- Sub-module uart_tx_byte, the byte serializer:
  - inputs: clk, reset, load, data[7:0]; outputs: txd, ready (last stop-bit cycle); parameter CLKS_PER_BIT.
  - The top-level FSM sequences bytes and the register walk around it.

## Test plan
All scenarios use CLKS_PER_BIT=4. The processor debug port is modeled as dbg_val = 32'hDEAD0000 | dbg_sel.
- Reset: assert reset for 2 cycles -> txd=1, busy=0, done=0, dbg_sel=0. No activity for 100 cycles without start.
- Full dump: pulse start; the UART monitor decodes 65 bytes: A5, then DE AD 00 00, DE AD 00 01, …, DE AD 00 0F. No framing errors.
- Timing check during the full dump:
  - every bit is exactly 4 cycles.
  - busy is high exactly 2632 cycles.
  - exactly two idle cycles before each register's first start bit.
  - done is a single pulse immediately after busy falls.
- Start while busy, or in the done cycle: no effect, and the frame is unchanged. A start 1 cycle after done produces a second identical 65-byte frame.
- Reset mid-dump during R5 byte 2: the next cycle gives txd=1, busy=0, dbg_sel=0. A subsequent start yields a complete frame beginning A5, DE AD 00 00.
- Capture point: change R3's value to 32'h12345678 one cycle after its CAP cycle -> the old value DE AD 00 03 is transmitted for R3.
